// File: rtl/regfile_scoreboard_if.sv
// Decode-stage register file bus: write port, two read ports, scoreboard, clear and flags.
// Width parameters must match the regfile_scoreboard instance they connect to.
interface regfile_scoreboard_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic              WriteReg;
    logic [ADDR_W-1:0] DstReg;
    logic [DATA_W-1:0] DstData;
    logic [ADDR_W-1:0] SrcReg1;
    logic [ADDR_W-1:0] SrcReg2;
    logic [DATA_W-1:0] SrcData1;
    logic [DATA_W-1:0] SrcData2;
    logic              SrcBusy1;
    logic              SrcBusy2;
    logic              alloc_en;
    logic [ADDR_W-1:0] alloc_reg;
    logic              clr_req;
    logic              clr_busy;
    logic [2:0]        flag_in;
    logic [2:0]        flag_en;
    logic [2:0]        flag_out;

    modport master (
        output WriteReg, DstReg, DstData, SrcReg1, SrcReg2,
        output alloc_en, alloc_reg, clr_req, flag_in, flag_en,
        input  SrcData1, SrcData2, SrcBusy1, SrcBusy2, clr_busy, flag_out
    );

    modport slave (
        input  WriteReg, DstReg, DstData, SrcReg1, SrcReg2,
        input  alloc_en, alloc_reg, clr_req, flag_in, flag_en,
        output SrcData1, SrcData2, SrcBusy1, SrcBusy2, clr_busy, flag_out
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with write-bypass, scoreboard busy bits, sequenced bulk clear and Z/O/N flags.
// Optional macro RF_R0_ZERO_EN: register 0 is hardwired to zero and never marked busy.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16
) (
    input logic                clk,
    input logic                rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);
`ifdef RF_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                             state_q, state_d;
    logic [ADDR_W-1:0]                  clr_ptr_q, clr_ptr_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;
    logic [NUM_REGS-1:0]                busy_q, busy_d;
    logic [2:0]                         flag_q, flag_d;

    logic                               wr_ok;
    logic [1:0][ADDR_W-1:0]             src_reg;
    logic [1:0][DATA_W-1:0]             src_data;
    logic [1:0]                         src_busy;

    // Out-of-range destinations still pass here; they simply match no register.
    assign wr_ok   = (state_q == IDLE) && bus.WriteReg && !(R0_ZERO && bus.DstReg == '0);
    assign src_reg = {bus.SrcReg2, bus.SrcReg1};

    always_comb begin
        src_data = '0;
        src_busy = '0;
        for (int p = 0; p < 2; p++) begin
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (src_reg[p] == ADDR_W'(i) && !(R0_ZERO && i == 0)) begin
                    hit         = 1'b1;
                    src_data[p] = regs_q[i];
                    src_busy[p] = busy_q[i];
                end
            end
            if (hit && wr_ok && bus.DstReg == src_reg[p]) begin
                src_data[p] = bus.DstData;
                src_busy[p] = 1'b0;
            end
        end
    end

    assign bus.SrcData1 = src_data[0];
    assign bus.SrcData2 = src_data[1];
    assign bus.SrcBusy1 = src_busy[0];
    assign bus.SrcBusy2 = src_busy[1];
    assign bus.clr_busy = (state_q == CLEAR);
    assign bus.flag_out = flag_q;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        regs_d    = regs_q;
        busy_d    = busy_q;
        for (int b = 0; b < 3; b++)
            flag_d[b] = bus.flag_en[b] ? bus.flag_in[b] : flag_q[b];

        case (state_q)
            IDLE: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_ok && bus.DstReg == ADDR_W'(i)) begin
                        regs_d[i] = bus.DstData;
                        busy_d[i] = 1'b0;
                    end
                    // Allocation after writeback so a new producer keeps the register busy.
                    if (bus.alloc_en && bus.alloc_reg == ADDR_W'(i) && !(R0_ZERO && i == 0))
                        busy_d[i] = 1'b1;
                end
                clr_ptr_d = '0;
                if (bus.clr_req) state_d = CLEAR;
            end
            CLEAR: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (clr_ptr_q == ADDR_W'(i)) begin
                        regs_d[i] = '0;
                        busy_d[i] = 1'b0;
                    end
                end
                if (clr_ptr_q == ADDR_W'(NUM_REGS - 1)) begin
                    clr_ptr_d = '0;
                    state_d   = IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_ptr_q <= '0;
            regs_q    <= '0;
            busy_q    <= '0;
            flag_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            flag_q    <= flag_d;
        end
    end
endmodule
